mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_pkg.sv | 59 +++++
 rtl/mbist_march_ctrl_if.sv | 43 ++++
 rtl/mbist_cmp.sv | 104 ++++++++++
 rtl/mbist_march_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// Shared types and per-element March C- constants for the MBIST controller and its compare unit.
package mbist_pkg;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Cycles spent waiting for the last read to come back before DONE
    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

    function automatic logic elem_dir_up(input elem_e e);
        case (e)
            E3, E4:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic elem_rd_val(input elem_e e);
        case (e)
            E2, E4:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic elem_wr_val(input elem_e e);
        case (e)
            E1, E3:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] elem_op_cnt(input elem_e e);
        case (e)
            E0, E5:  return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // Single-op elements: E0 is the write-only one, E5 the read-only one
    function automatic logic elem_has_rd(input elem_e e);
        case (e)
            E0:      return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Control/status and memory-port bundle of the MBIST controller.
// The fail_* log signals exist only when MBIST_FAIL_LOG_EN is defined.
interface mbist_march_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CNT_WIDTH-1:0]  fail_cnt;
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
`ifdef MBIST_FAIL_LOG_EN
    logic                  fail_vld;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [2:0]            fail_elem;
    logic [DATA_WIDTH-1:0] fail_bits;

    modport master (
        input  start, rdata,
        output busy, done, pass, fail_cnt, write_read, address, wdata,
        output fail_vld, fail_addr, fail_elem, fail_bits
    );
    modport slave (
        output start, rdata,
        input  busy, done, pass, fail_cnt, write_read, address, wdata,
        input  fail_vld, fail_addr, fail_elem, fail_bits
    );
`else
    modport master (
        input  start, rdata,
        output busy, done, pass, fail_cnt, write_read, address, wdata
    );
    modport slave (
        output start, rdata,
        input  busy, done, pass, fail_cnt, write_read, address, wdata
    );
`endif
endinterface

// File: rtl/mbist_cmp.sv
// Read-data checker: 2-stage expectation pipeline aligned to rdata, saturating mismatch counter
// and, with MBIST_FAIL_LOG_EN, a first-fail log.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  push_vld_i,
    input  logic [DATA_WIDTH-1:0] push_exp_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [CNT_WIDTH-1:0]  fail_cnt_o
`ifdef MBIST_FAIL_LOG_EN
    ,
    input  elem_e                 push_elem_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    output logic                  fail_vld_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_bits_o
`endif
);
    logic                  s1_vld_q, s2_vld_q;
    logic [DATA_WIDTH-1:0] s1_exp_q, s2_exp_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] diff_s;
    logic                  mism_s;
`ifdef MBIST_FAIL_LOG_EN
    elem_e                 s1_elem_q, s2_elem_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
    logic                  log_vld_q;
    logic [ADDR_WIDTH-1:0] log_addr_q;
    elem_e                 log_elem_q;
    logic [DATA_WIDTH-1:0] log_bits_q;
`endif

    // Compare the oldest pipeline entry against the returning read data
    always_comb begin
        diff_s = rdata_i ^ s2_exp_q;
        mism_s = s2_vld_q & (diff_s != {DATA_WIDTH{1'b0}});
    end

    // Pipeline shift and saturating mismatch count
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_exp_q <= {DATA_WIDTH{1'b0}};
            s2_exp_q <= {DATA_WIDTH{1'b0}};
            cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            s1_vld_q <= push_vld_i;
            s2_vld_q <= s1_vld_q;
            s1_exp_q <= push_exp_i;
            s2_exp_q <= s1_exp_q;
            if (mism_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    assign fail_cnt_o = cnt_q;

`ifdef MBIST_FAIL_LOG_EN
    // First-fail capture; later mismatches leave the log untouched
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            s1_elem_q  <= E0;
            s2_elem_q  <= E0;
            s1_addr_q  <= {ADDR_WIDTH{1'b0}};
            s2_addr_q  <= {ADDR_WIDTH{1'b0}};
            log_vld_q  <= 1'b0;
            log_addr_q <= {ADDR_WIDTH{1'b0}};
            log_elem_q <= E0;
            log_bits_q <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_elem_q <= push_elem_i;
            s2_elem_q <= s1_elem_q;
            s1_addr_q <= push_addr_i;
            s2_addr_q <= s1_addr_q;
            if (mism_s && !log_vld_q) begin
                log_vld_q  <= 1'b1;
                log_addr_q <= s2_addr_q;
                log_elem_q <= s2_elem_q;
                log_bits_q <= diff_s;
            end else begin
                log_vld_q  <= log_vld_q;
            end
        end
    end

    assign fail_vld_o  = log_vld_q;
    assign fail_addr_o = log_addr_q;
    assign fail_elem_o = log_elem_q;
    assign fail_bits_o = log_bits_q;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine: op generator one cycle ahead of a registered memory port, run/drain/done control.
// MBIST_FAIL_LOG_EN adds first-fail capture in mbist_cmp.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mbist_march_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [1:0]            drain_q, drain_d;
    logic                  gen_vld_q, gen_vld_d;
    elem_e                 gen_elem_q, gen_elem_d, elem_nxt_s;
    logic [ADDR_WIDTH-1:0] gen_addr_q, gen_addr_d, addr_end_s;
    logic                  gen_ph_q, gen_ph_d;
    logic                  gen_wr_s, gen_wr_d, gen_last_s, start_acc_s;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [ADDR_WIDTH-1:0] address_q;
    logic                  write_read_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rd_vld_q, rd_exp_q, op_last_q;
    logic                  busy_q, done_q, pass_q;
    logic [CNT_WIDTH-1:0]  fail_cnt_s;
`ifdef MBIST_FAIL_LOG_EN
    elem_e                 rd_elem_q;
`endif

    // Decode of the op currently held by the generator
    always_comb begin
        gen_wr_s    = (elem_op_cnt(gen_elem_q) == 2'd2) ? gen_ph_q : ~elem_has_rd(gen_elem_q);
        gen_last_s  = gen_vld_q & (gen_elem_q == E5) & (gen_addr_q == ADDR_MAX);
        start_acc_s = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        elem_nxt_s  = (gen_elem_q == E5) ? E5 : elem_e'(gen_elem_q + 3'd1);
        addr_end_s  = elem_dir_up(gen_elem_q) ? ADDR_MAX : ADDR_ZERO;
    end

    // Next state and op-generator stepping: read before write at each address, then move the address
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        gen_vld_d  = gen_vld_q;
        gen_elem_d = gen_elem_q;
        gen_addr_d = gen_addr_q;
        gen_ph_d   = gen_ph_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    gen_vld_d  = 1'b1;
                    gen_elem_d = E0;
                    gen_addr_d = ADDR_ZERO;
                    gen_ph_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (op_last_q) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd0;
                end else begin
                    state_d = ST_RUN;
                end
                if (gen_last_s) begin
                    gen_vld_d = 1'b0;
                end else if (gen_vld_q) begin
                    if ((elem_op_cnt(gen_elem_q) == 2'd2) && !gen_ph_q) begin
                        gen_ph_d = 1'b1;
                    end else begin
                        gen_ph_d = 1'b0;
                        if (gen_addr_q == addr_end_s) begin
                            gen_elem_d = elem_nxt_s;
                            gen_addr_d = elem_dir_up(elem_nxt_s) ? ADDR_ZERO : ADDR_MAX;
                        end else if (elem_dir_up(gen_elem_q)) begin
                            gen_addr_d = gen_addr_q + ADDR_ONE;
                        end else begin
                            gen_addr_d = gen_addr_q - ADDR_ONE;
                        end
                    end
                end else begin
                    gen_vld_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == (DRAIN_CYCLES - 2'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gen_wr_d = (elem_op_cnt(gen_elem_d) == 2'd2) ? gen_ph_d : ~elem_has_rd(gen_elem_d);
        wdata_d  = (gen_vld_d && gen_wr_d) ? {DATA_WIDTH{elem_wr_val(gen_elem_d)}} : {DATA_WIDTH{1'b0}};
    end

    // State, generator and memory-port registers; wdata leads address by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            drain_q      <= 2'd0;
            gen_vld_q    <= 1'b0;
            gen_elem_q   <= E0;
            gen_addr_q   <= ADDR_ZERO;
            gen_ph_q     <= 1'b0;
            address_q    <= ADDR_ZERO;
            write_read_q <= 1'b0;
            wdata_q      <= {DATA_WIDTH{1'b0}};
            rd_vld_q     <= 1'b0;
            rd_exp_q     <= 1'b0;
            op_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            gen_vld_q  <= gen_vld_d;
            gen_elem_q <= gen_elem_d;
            gen_addr_q <= gen_addr_d;
            gen_ph_q   <= gen_ph_d;
            wdata_q    <= wdata_d;
            if (gen_vld_q) begin
                address_q    <= gen_addr_q;
                write_read_q <= gen_wr_s;
                rd_vld_q     <= ~gen_wr_s;
                rd_exp_q     <= elem_rd_val(gen_elem_q);
                op_last_q    <= gen_last_s;
            end else begin
                address_q    <= address_q;
                write_read_q <= 1'b0;
                rd_vld_q     <= 1'b0;
                rd_exp_q     <= 1'b0;
                op_last_q    <= 1'b0;
            end
            busy_q <= (state_d == ST_RUN) | (state_q == ST_RUN) | (state_q == ST_DRAIN);
            done_q <= (state_q == ST_DONE) & (state_d == ST_DONE);
            pass_q <= (state_q == ST_DONE) & (state_d == ST_DONE) & (fail_cnt_s == {CNT_WIDTH{1'b0}});
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    // Element tag travelling with each issued read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_elem_q <= E0;
        end else if (gen_vld_q) begin
            rd_elem_q <= gen_elem_q;
        end else begin
            rd_elem_q <= rd_elem_q;
        end
    end
`endif

    mbist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start_acc_s),
        .push_vld_i  (rd_vld_q),
        .push_exp_i  ({DATA_WIDTH{rd_exp_q}}),
        .rdata_i     (bus.rdata),
        .fail_cnt_o  (fail_cnt_s)
`ifdef MBIST_FAIL_LOG_EN
        ,
        .push_elem_i (rd_elem_q),
        .push_addr_i (address_q),
        .fail_vld_o  (bus.fail_vld),
        .fail_addr_o (bus.fail_addr),
        .fail_elem_o (bus.fail_elem),
        .fail_bits_o (bus.fail_bits)
`endif
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_cnt   = fail_cnt_s;
    assign bus.write_read = write_read_q;
    assign bus.address    = address_q;
    assign bus.wdata      = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a 2-cycle-latency memory model and optional stuck-at fault.
// Fail-log checks are active when MBIST_FAIL_LOG_EN is defined.
module tb_mbist_march_ctrl;
    localparam int NW   = 16;
    localparam int NOPS = 160;
    localparam int LAT  = 164;

    logic clk = 1'b0;
    logic rst_n;
    int   ecnt   = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   s_edge = 0;
    bit   stuck_en = 1'b0;

    logic [7:0] mem [NW];
    logic [7:0] wd_d1;
    logic [7:0] rd_d1;
    logic [3:0] exp_addr [NOPS];
    logic       exp_wr   [NOPS];
    logic [7:0] exp_wd   [NOPS];
    logic [3:0] obs_addr [NOPS];
    logic       obs_wr   [NOPS];

    mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) bus ();

    mbist_march_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .CAPACITY   (15),
        .CNT_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Memory: wdata taken one cycle before its address, read data two cycles after the address
    always @(posedge clk) begin
        if (ecnt == 0) begin
            for (int i = 0; i < NW; i++) mem[i] <= 8'hA5;
        end else if (bus.write_read) begin
            mem[bus.address] <= wd_d1;
        end
        wd_d1 <= bus.wdata;
        if (stuck_en && bus.address == 4'd9) rd_d1 <= mem[bus.address] & 8'hF7;
        else rd_d1 <= mem[bus.address];
        bus.rdata <= rd_d1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        s_edge = ecnt;
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_busy"},  bus.busy,       1'b0);
        chk_eq({tag, "_done"},  bus.done,       1'b0);
        chk_eq({tag, "_pass"},  bus.pass,       1'b0);
        chk_eq({tag, "_cnt"},   bus.fail_cnt,   16'd0);
        chk_eq({tag, "_wr"},    bus.write_read, 1'b0);
        chk_eq({tag, "_addr"},  bus.address,    4'd0);
        chk_eq({tag, "_wdata"}, bus.wdata,      8'd0);
    endtask

    // Walk one full test after start, checking each op against the March C- table
    task automatic run_trace();
        if (exp_wr[0]) chk_eq("op0_wdata", bus.wdata, exp_wd[0]);
        for (int i = 1; i <= NOPS; i++) begin
            step();
            obs_addr[i-1] = bus.address;
            obs_wr[i-1]   = bus.write_read;
            chk_eq($sformatf("op%0d_addr", i-1), bus.address, exp_addr[i-1]);
            chk_eq($sformatf("op%0d_wr", i-1), bus.write_read, exp_wr[i-1]);
            if (i < NOPS && exp_wr[i]) chk_eq($sformatf("op%0d_wdata", i), bus.wdata, exp_wd[i]);
        end
    endtask

    task automatic wait_done(input string tag);
        logic busy_prev;
        busy_prev = bus.busy;
        while (bus.done !== 1'b1 && (ecnt - s_edge) < LAT + 40) begin
            busy_prev = bus.busy;
            step();
        end
        chk_eq({tag, "_done_edge"}, ecnt - s_edge, LAT);
        chk_eq({tag, "_busy_before"}, busy_prev, 1'b1);
        chk_eq({tag, "_busy_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        int k;
        int a;
        k = 0;
        for (int j = 0; j < NW; j++) begin
            exp_addr[k] = 4'(j); exp_wr[k] = 1'b1; exp_wd[k] = 8'h00; k++;
        end
        for (int e = 1; e <= 4; e++) begin
            for (int j = 0; j < NW; j++) begin
                a = (e >= 3) ? (NW - 1 - j) : j;
                exp_addr[k] = 4'(a); exp_wr[k] = 1'b0; exp_wd[k] = 8'h00; k++;
                exp_addr[k] = 4'(a); exp_wr[k] = 1'b1;
                exp_wd[k] = (e == 1 || e == 3) ? 8'hFF : 8'h00; k++;
            end
        end
        for (int j = 0; j < NW; j++) begin
            exp_addr[k] = 4'(j); exp_wr[k] = 1'b0; exp_wd[k] = 8'h00; k++;
        end

        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("idle");

        // Tests 1/2: fault-free run with start at edge 10 and full trace
        while (ecnt < 9) step();
        do_start();
        chk_eq("t1_busy_rise", bus.busy, 1'b1);
        run_trace();
        chk_eq("t2_e3_first_addr", obs_addr[80], 4'd15);
        chk_eq("t2_e3_first_is_read", obs_wr[80], 1'b0);
        chk_eq("t2_e5_last_addr", obs_addr[159], 4'd15);
        step();
        chk_eq("t1_no_op_after_160", bus.write_read, 1'b0);
        wait_done("t1");
        chk_eq("t1_done_edge_abs", ecnt, 174);
        chk_eq("t1_pass", bus.pass, 1'b1);
        chk_eq("t1_cnt", bus.fail_cnt, 16'd0);
        step();
        chk_eq("t1_done_held", bus.done, 1'b1);

        // Test 3/5: bit 3 of word 9 stuck at 0
        stuck_en = 1'b1;
        do_start();
        chk_eq("t3_done_clear", bus.done, 1'b0);
        wait_done("t3");
        chk_eq("t3_pass", bus.pass, 1'b0);
        chk_eq("t3_cnt", bus.fail_cnt, 16'd2);
`ifdef MBIST_FAIL_LOG_EN
        chk_eq("t5_fail_vld",  bus.fail_vld,  1'b1);
        chk_eq("t5_fail_addr", bus.fail_addr, 4'd9);
        chk_eq("t5_fail_elem", bus.fail_elem, 3'd2);
        chk_eq("t5_fail_bits", bus.fail_bits, 8'h08);
`endif

        // Test 6: start from DONE clears status; re-pulses in RUN and DRAIN are ignored
        stuck_en = 1'b0;
        do_start();
        chk_eq("t6_done_clear", bus.done, 1'b0);
        chk_eq("t6_pass_clear", bus.pass, 1'b0);
        chk_eq("t6_cnt_clear", bus.fail_cnt, 16'd0);
        chk_eq("t6_busy", bus.busy, 1'b1);
`ifdef MBIST_FAIL_LOG_EN
        chk_eq("t6_log_clear", bus.fail_vld, 1'b0);
`endif
        while ((ecnt - s_edge) < 50) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while ((ecnt - s_edge) < 161) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("t6");
        chk_eq("t6_pass", bus.pass, 1'b1);

        // Test 4: one-cycle reset at op 70, then a clean rerun
        do_start();
        while ((ecnt - s_edge) < 71) step();
        chk_eq("t4_busy_mid", bus.busy, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle("t4_rst");
        repeat (3) step();
        chk_eq("t4_stay_idle", bus.busy, 1'b0);
        do_start();
        wait_done("t4");
        chk_eq("t4_pass", bus.pass, 1'b1);
        chk_eq("t4_cnt", bus.fail_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
